spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_rr_pick.sv | 38 +++
 rtl/spi_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: constants and FSM state encoding shared by the SPI arbiter and the SPI master.
package spi_pkg;

  // Default payload width, matching the SPI master din port.
  localparam int unsigned SPI_WORD_W = 12;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  // Index width needed to address n requesters (never below one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: combinational round-robin pick, searching upward from ptr_i and wrapping at NREQ.
module spi_rr_pick
  import spi_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_c_o,
  output logic [PW-1:0]   idx_c_o,
  output logic            valid_c_o
);

  logic [31:0]   cand;
  logic [PW-1:0] cand_idx;

  // First requester at or after ptr_i, modulo NREQ.
  always_comb begin
    gnt_c_o   = '0;
    idx_c_o   = '0;
    valid_c_o = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand     = (32'(ptr_i) + k) % NREQ;
      cand_idx = PW'(cand);
      if (!valid_c_o && req_i[cand_idx]) begin
        valid_c_o = 1'b1;
        idx_c_o   = cand_idx;
      end
    end
    if (valid_c_o) begin
      gnt_c_o[idx_c_o] = 1'b1;
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one SPI master among NREQ requesters.
// Optional watchdog on the SPI handshake is built when SPI_ARB_TIMEOUT_EN is defined.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned WORD_W         = SPI_WORD_W,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WORD_W-1:0] data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   spi_newd,
  output logic [WORD_W-1:0]      spi_din,
  input  logic                   spi_cs,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned PW = idx_w(NREQ);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   sel_q, sel_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              newd_q, newd_d;
  logic [WORD_W-1:0] din_q, din_d;
  logic              busy_q, busy_d;
  logic              cs_meta_q, cs_s_q;
  logic              timeout_c;

  logic [NREQ-1:0]   pick_gnt_c;
  logic [PW-1:0]     pick_idx_c;
  logic              pick_valid_c;
  logic [WORD_W-1:0] data_w [NREQ];

  // Split the flat payload bus into per-requester words.
  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign data_w[g] = data[g*WORD_W +: WORD_W];
  end

  // Two-flop synchronizer for the SPI master chip select (idle high).
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta_q <= 1'b1;
      cs_s_q    <= 1'b1;
    end else begin
      cs_meta_q <= spi_cs;
      cs_s_q    <= cs_meta_q;
    end
  end

  spi_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_c_o   (pick_gnt_c),
    .idx_c_o   (pick_idx_c),
    .valid_c_o (pick_valid_c)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  // Watchdog: counts cycles spent in LAUNCH/WAIT, restarting on every state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if ((state_d != state_q) || !((state_q == LAUNCH) || (state_q == WAIT))) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign timeout_c = ((state_q == LAUNCH) || (state_q == WAIT)) &&
                     (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Single-cycle error pulse on watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_c;
    end
  end

  assign err = err_q;
`else
  assign timeout_c = 1'b0;
  assign err       = 1'b0;

  // The watchdog limit only matters when the watchdog is built in.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
  end
`endif

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      newd_q  <= 1'b0;
      din_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      newd_q  <= newd_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic; outputs appear with the state they belong to.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = '0;
    done_d  = '0;
    newd_d  = 1'b0;
    din_d   = din_q;
    busy_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          state_d = LAUNCH;
          gnt_d   = pick_gnt_c;
          sel_d   = pick_gnt_c;
          din_d   = data_w[pick_idx_c];
          newd_d  = 1'b1;
          ptr_d   = (pick_idx_c == PW'(NREQ - 1)) ? '0 : pick_idx_c + PW'(1);
        end
      end
      LAUNCH: begin
        if (!cs_s_q) begin
          state_d = WAIT;
        end else begin
          newd_d = 1'b1;
        end
      end
      WAIT: begin
        if (cs_s_q) begin
          state_d = DONE;
          done_d  = sel_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Watchdog abort: only when the handshake made no progress this cycle.
    if (timeout_c && (state_d == state_q)) begin
      state_d = IDLE;
      newd_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign spi_newd = newd_q;
  assign spi_din  = din_q;
  assign busy     = busy_q;

endmodule
